// File: rtl/vga_timing_if.sv
// VGA timing bundle: raster position counters plus sync/blank flags.
// The generator drives it through the out (or master) modport; consumers use slave.
interface vga_tim;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;

  modport master (output hcount, hsync, hblnk, vcount, vsync, vblnk);
  modport out    (output hcount, hsync, hblnk, vcount, vsync, vblnk);
  modport slave  (input  hcount, hsync, hblnk, vcount, vsync, vblnk);
endinterface

// File: rtl/vga_timing.sv
// VGA raster timing generator: 11-bit h/v counters with registered sync, blank and sof.
// Optional macro VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame counter output.
module vga_timing #(
  parameter int HACTIVE = 800,
  parameter int HFP     = 40,
  parameter int HSW     = 128,
  parameter int HBP     = 88,
  parameter int VACTIVE = 600,
  parameter int VFP     = 1,
  parameter int VSW     = 4,
  parameter int VBP     = 23
) (
  input  logic clk,
  input  logic rst,
  vga_tim.out  out,
  output logic sof
`ifdef VGA_TIMING_FRAME_CNT_EN
  , output logic [15:0] frame_cnt
`endif
);

  localparam int HTOTAL = HACTIVE + HFP + HSW + HBP;
  localparam int VTOTAL = VACTIVE + VFP + VSW + VBP;

  localparam logic [10:0] H_LAST = 11'(HTOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(VTOTAL - 1);

  // Thresholds kept 12 bits wide so a sync window ending exactly at 2048 still compares correctly.
  localparam logic [11:0] H_BLNK_START = 12'(HACTIVE);
  localparam logic [11:0] H_SYNC_START = 12'(HACTIVE + HFP);
  localparam logic [11:0] H_SYNC_END   = 12'(HACTIVE + HFP + HSW);
  localparam logic [11:0] V_BLNK_START = 12'(VACTIVE);
  localparam logic [11:0] V_SYNC_START = 12'(VACTIVE + VFP);
  localparam logic [11:0] V_SYNC_END   = 12'(VACTIVE + VFP + VSW);

  logic [10:0] hcount_q, vcount_q;
  logic        hsync_q, hblnk_q, vsync_q, vblnk_q, sof_q;

  logic [10:0] hcount_d, vcount_d;
  logic        h_wrap, v_last, frame_wrap;
  logic [11:0] h_ext, v_ext;

  always_comb begin
    h_wrap     = (hcount_q == H_LAST);
    v_last     = (vcount_q == V_LAST);
    frame_wrap = h_wrap && v_last;
    hcount_d   = h_wrap ? '0 : hcount_q + 11'd1;
    vcount_d   = vcount_q;
    if (h_wrap) begin
      vcount_d = v_last ? '0 : vcount_q + 11'd1;
    end
    h_ext = {1'b0, hcount_d};
    v_ext = {1'b0, vcount_d};
  end

  // Flags are decoded from the next-state counts so they land in the same cycle as the counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      vsync_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      sof_q    <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hblnk_q  <= (h_ext >= H_BLNK_START);
      hsync_q  <= (h_ext >= H_SYNC_START) && (h_ext < H_SYNC_END);
      vblnk_q  <= (v_ext >= V_BLNK_START);
      vsync_q  <= (v_ext >= V_SYNC_START) && (v_ext < V_SYNC_END);
      sof_q    <= frame_wrap;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (frame_wrap) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign out.hcount = hcount_q;
  assign out.vcount = vcount_q;
  assign out.hsync  = hsync_q;
  assign out.hblnk  = hblnk_q;
  assign out.vsync  = vsync_q;
  assign out.vblnk  = vblnk_q;
  assign sof        = sof_q;

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: a small-mode DUT (many frames) and a default-mode DUT
// (many lines) share a randomly pulsed reset and are checked against a cycle-count raster model.
module tb_vga_timing;

  localparam int S_HA = 10, S_HFP = 3, S_HSW = 5, S_HBP = 4;
  localparam int S_VA = 6,  S_VFP = 2, S_VSW = 3, S_VBP = 2;
  localparam int D_HA = 800, D_HFP = 40, D_HSW = 128, D_HBP = 88;
  localparam int D_VA = 600, D_VFP = 1,  D_VSW = 4,   D_VBP = 23;
  localparam int NCYC = 25000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sof_s, sof_d;

  vga_tim tim_s ();
  vga_tim tim_d ();

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc_s, fc_d;
`endif

  vga_timing #(
    .HACTIVE(S_HA), .HFP(S_HFP), .HSW(S_HSW), .HBP(S_HBP),
    .VACTIVE(S_VA), .VFP(S_VFP), .VSW(S_VSW), .VBP(S_VBP)
  ) dut_s (
    .clk(clk), .rst(rst), .out(tim_s), .sof(sof_s)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc_s)
`endif
  );

  vga_timing #(
    .HACTIVE(D_HA), .HFP(D_HFP), .HSW(D_HSW), .HBP(D_HBP),
    .VACTIVE(D_VA), .VFP(D_VFP), .VSW(D_VSW), .VBP(D_VBP)
  ) dut_d (
    .clk(clk), .rst(rst), .out(tim_d), .sof(sof_d)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc_d)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [26:0] exp_s;
    logic [26:0] exp_d;
    logic [15:0] fc_s;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   drive_done = 1'b0;

  // p = cycles since reset released; raster position follows from plain division.
  function automatic logic [26:0] model(input longint p, input longint ha, input longint hfp,
                                        input longint hsw, input longint hbp, input longint va,
                                        input longint vfp, input longint vsw, input longint vbp);
    longint ht, vt, h, v;
    logic hs, hb, vs, vb, sf;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    h  = p % ht;
    v  = (p / ht) % vt;
    hb = (h >= ha);
    hs = (h >= ha + hfp) && (h < ha + hfp + hsw);
    vb = (v >= va);
    vs = (v >= va + vfp) && (v < va + vfp + vsw);
    sf = (p > 0) && ((p % (ht * vt)) == 0);
    return {11'(h), 11'(v), hs, hb, vs, vb, sf};
  endfunction

  task automatic compare(input string name, input logic [26:0] got, input logic [26:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got h=%0d v=%0d hs/hb/vs/vb/sof=%05b, want h=%0d v=%0d hs/hb/vs/vb/sof=%05b",
               name, got[26:16], got[15:5], got[4:0], want[26:16], want[15:5], want[4:0]);
    end
  endtask

  // Driver: pick reset for the coming edge, push what both DUTs must show after it.
  initial begin
    longint p = 0;
    exp_t e;
    for (int unsigned i = 0; i < NCYC; i++) begin
      @(negedge clk);
      rst = (i < 5) || (i == 3000) || ($urandom_range(0, 4095) == 0);
      p = rst ? 0 : p + 1;
      e.exp_s = model(p, S_HA, S_HFP, S_HSW, S_HBP, S_VA, S_VFP, S_VSW, S_VBP);
      e.exp_d = model(p, D_HA, D_HFP, D_HSW, D_HBP, D_VA, D_VFP, D_VSW, D_VBP);
      e.fc_s  = 16'((p / ((S_HA + S_HFP + S_HSW + S_HBP) * (S_VA + S_VFP + S_VSW + S_VBP))) % 65536);
      if (rst) begin
        e.exp_s = '0;
        e.exp_d = '0;
        e.fc_s  = '0;
      end
      sb.push_back(e);
    end
    drive_done = 1'b1;
  end

  // Monitor: every cycle presents a raster sample; pop and compare just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        compare("small", {tim_s.hcount, tim_s.vcount, tim_s.hsync, tim_s.hblnk,
                          tim_s.vsync, tim_s.vblnk, sof_s}, e.exp_s);
        compare("default", {tim_d.hcount, tim_d.vcount, tim_d.hsync, tim_d.hblnk,
                            tim_d.vsync, tim_d.vblnk, sof_d}, e.exp_d);
`ifdef VGA_TIMING_FRAME_CNT_EN
        checks++;
        if (fc_s !== e.fc_s) begin
          errors++;
          $display("FAIL frame_cnt: got %0d, want %0d", fc_s, e.fc_s);
        end
`endif
      end
    end
  end

  initial begin
    int unsigned budget;
    wait (drive_done);
    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter HACTIVE, default 800, visible pixels per line.
REQ-002 SHALL have parameter HFP, default 40, horizontal front porch in pixels.
REQ-003 SHALL have parameter HSW, default 128, hsync width in pixels.
REQ-004 SHALL have parameter HBP, default 88, horizontal back porch in pixels.
REQ-005 SHALL have parameter VACTIVE, default 600, visible lines per frame.
REQ-006 SHALL have parameter VFP, default 1, vertical front porch in lines.
REQ-007 SHALL have parameter VSW, default 4, vsync width in lines.
REQ-008 SHALL have parameter VBP, default 23, vertical back porch in lines.
REQ-009 SHALL have port clk, input, 1, pixel clock (40 MHz for the default 800x600@60 mode); single clock domain.
REQ-010 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-011 SHALL have port out, vga_tim.out modport, carrying hcount[10:0], hsync, hblnk, vcount[10:0], vsync and vblnk.
REQ-012 SHALL have port sof, output, 1, start-of-frame strobe.

Function
REQ-013 SHALL derive HTOTAL = HACTIVE+HFP+HSW+HBP (default 1056) and VTOTAL = VACTIVE+VFP+VSW+VBP (default 628).
REQ-014 SHALL increment hcount by 1 every clk cycle when rst=0.
REQ-015 SHALL wrap hcount from HTOTAL-1 to 0 and, in that same cycle, increment vcount.
REQ-016 SHALL wrap vcount from VTOTAL-1 to 0 when hcount wraps at vcount=VTOTAL-1, so the sequence (HTOTAL-1,VTOTAL-1) -> (0,0).
REQ-017 SHALL drive all out signals and sof from flops, registered from next-state counter values, so every flag is aligned with the hcount/vcount shown in the same cycle (zero relative skew).
REQ-018 SHALL assert hblnk iff hcount >= HACTIVE.
REQ-019 SHALL assert hsync iff HACTIVE+HFP <= hcount < HACTIVE+HFP+HSW (default 840..967), active-high.
REQ-020 SHALL assert vblnk iff vcount >= VACTIVE.
REQ-021 SHALL assert vsync iff VACTIVE+VFP <= vcount < VACTIVE+VFP+VSW (default 601..604), active-high, for complete lines.
REQ-022 SHALL pulse sof for exactly one cycle, the cycle in which out shows (0,0) after a wrap from (HTOTAL-1,VTOTAL-1); it SHALL NOT be asserted for the (0,0) held during or immediately out of reset.
REQ-023 SHALL keep hcount < HTOTAL and vcount < VTOTAL at all times; 11-bit counters, unsigned compare only.
REQ-024 SHALL give parameter sets with HTOTAL>2048 or VTOTAL>2048 undefined behaviour; no runtime check is required.

Reset
REQ-025 SHALL, while rst=1 at a clk edge, set hcount=0, vcount=0, hsync=0, hblnk=0, vsync=0, vblnk=0 and sof=0.
REQ-026 SHALL, on rst asserted mid-frame, reach the reset state at the next clk edge and restart counting from (0,0), with the first post-reset cycle showing (1,0).

Configuration
REQ-027 SHALL, with macro VGA_TIMING_FRAME_CNT_EN defined, add output port frame_cnt[15:0] that resets to 0 and increments, wrapping 0xFFFF->0, in the same cycle sof is asserted.
REQ-028 SHALL, without VGA_TIMING_FRAME_CNT_EN, omit frame_cnt and its flops, leaving all other behaviour unchanged.

Verification
REQ-029 Reset: hold rst=1 for 5 cycles, then release -> all outputs 0 during rst, then hcount=1 and vcount=0 on the first cycle after release, sof=0.
REQ-030 Line wrap: run to hcount=1055, vcount=10 -> next cycle hcount=0, vcount=11; hblnk is 0 at hcount=799 and 1 at 800; hsync is 1 exactly for hcount 840..967 (128 cycles).
REQ-031 Frame wrap: run to (1055,627) -> next cycle (0,0) with sof=1 for one cycle; sof period = 663168 cycles; vsync is high for exactly 4 lines (vcount 601..604); vblnk is high for vcount 600..627.
REQ-032 Mid-frame reset: assert rst for 1 cycle at (500,300) -> next cycle (0,0) with all flags 0 and sof=0; counting then resumes from (1,0).
REQ-033 Macro on: run 3 frames -> frame_cnt steps 0->1->2->3 in exactly the sof cycles; preload near 0xFFFF (force) -> wraps to 0. Macro off: elaboration succeeds with no frame_cnt port.
REQ-034 Non-default parameters (HACTIVE=640, HFP=16, HSW=96, HBP=48, VACTIVE=480, VFP=10, VSW=2, VBP=33) -> HTOTAL=800, VTOTAL=525, hsync for hcount 656..751, vsync for vcount 490..491.
